pll_lock_monitor: RTL and testbench

Consumes the PLL lock indicator inside the 255.6 MHz acquisition clock domain. It produces a clean, filtered, synchronous reset and a ready flag for the signal-acquisition logic. Lock must be continuously stable for a programmable time before reset is released. Any later loss of lock immediately re-asserts reset, sets a sticky flag and increments a saturating loss counter for host readout.

---
 rtl/pll_lock_monitor.sv | 144 ++++++++++++++
 tb/tb_pll_lock_monitor.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pll_lock_monitor.sv
// pll_lock_monitor: turns a raw, asynchronous PLL lock indicator into a
// filtered synchronous reset and a ready flag for the acquisition logic.
// Lock must be stable for LOCK_FILTER cycles. Reset is then held for a
// further RESET_HOLD cycles before it is released. A loss of lock in RUN
// re-asserts reset at once. It also sets a sticky flag and bumps a
// saturating loss counter.
// Optional build macro PLL_LOCK_MONITOR_UPTIME_EN adds a 32-bit uptime
// output that counts cycles spent in RUN.
module pll_lock_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 1024,
  parameter int RESET_HOLD  = 256,
  parameter int LOSS_CNT_W  = 8
) (
  input  logic                  clock_in,
  input  logic                  reset,
  input  logic                  locked_async,
  input  logic                  clear_status,
  output logic                  rst_out,
  output logic                  ready,
  output logic                  lock_lost,
`ifdef PLL_LOCK_MONITOR_UPTIME_EN
  output logic [31:0]           uptime,
`endif
  output logic [LOSS_CNT_W-1:0] lock_loss_count
);

  localparam int MAXP = (LOCK_FILTER > RESET_HOLD) ? LOCK_FILTER : RESET_HOLD;
  localparam int CW   = (MAXP > 1) ? $clog2(MAXP) : 1;

  localparam logic [1:0] S_WAIT   = 2'd0;
  localparam logic [1:0] S_FILTER = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;
  localparam logic [1:0] S_RUN    = 2'd3;

  localparam logic [CW-1:0]         FILT_LAST = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0]         HOLD_LAST = CW'(RESET_HOLD - 1);
  localparam logic [LOSS_CNT_W-1:0] LOSS_MAX  = {LOSS_CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync;
  logic                   locked_sync;
  logic [1:0]             state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic                   loss_evt;

  assign locked_sync = sync[SYNC_STAGES-1];
  assign loss_evt    = (state == S_RUN) && !locked_sync;

  // Lock synchronizer shift chain, oldest sample in the top bit
  always_ff @(posedge clock_in) begin
    if (reset) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], locked_async};
  end

  // Next-state and phase-counter logic; any drop of lock falls back to WAIT
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_WAIT: begin
        if (locked_sync) begin
          state_nxt = S_FILTER;
          cnt_nxt   = '0;
        end
      end
      S_FILTER: begin
        if (!locked_sync) begin
          state_nxt = S_WAIT;
          cnt_nxt   = '0;
        end else if (cnt == FILT_LAST) begin
          state_nxt = S_HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_HOLD: begin
        if (!locked_sync) begin
          state_nxt = S_WAIT;
          cnt_nxt   = '0;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_RUN: begin
        if (!locked_sync) begin
          state_nxt = S_WAIT;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_WAIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, phase counter and registered rst_out/ready, which follow the next state
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state   <= S_WAIT;
      cnt     <= '0;
      rst_out <= 1'b1;
      ready   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rst_out <= (state_nxt != S_RUN);
      ready   <= (state_nxt == S_RUN);
    end
  end

  // Sticky loss flag and saturating loss counter; a loss beats a same-edge clear
  always_ff @(posedge clock_in) begin
    if (reset) begin
      lock_lost       <= 1'b0;
      lock_loss_count <= '0;
    end else if (loss_evt) begin
      lock_lost <= 1'b1;
      if (clear_status)                lock_loss_count <= LOSS_CNT_W'(1);
      else if (lock_loss_count != LOSS_MAX) lock_loss_count <= lock_loss_count + LOSS_CNT_W'(1);
    end else if (clear_status) begin
      lock_lost       <= 1'b0;
      lock_loss_count <= '0;
    end
  end

`ifdef PLL_LOCK_MONITOR_UPTIME_EN
  // RUN-cycle counter: 0 on the entry edge, saturates, zeroed on any exit
  always_ff @(posedge clock_in) begin
    if (reset) begin
      uptime <= '0;
    end else if ((state == S_RUN) && (state_nxt == S_RUN)) begin
      if (uptime != 32'hFFFF_FFFF) uptime <= uptime + 32'd1;
    end else begin
      uptime <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Table-driven bench for pll_lock_monitor. It uses small parameters:
// SYNC=2, FILTER=8, HOLD=4, LOSS_CNT_W=2. With these values ready rises
// 15 edges after the first high sample of locked_async.
module tb_pll_lock_monitor;

  logic       clk = 1'b0;
  logic       reset, locked_async, clear_status;
  logic       rst_out, ready, lock_lost;
  logic [1:0] lock_loss_count;
`ifdef PLL_LOCK_MONITOR_UPTIME_EN
  logic [31:0] uptime;
`endif

  always #5 clk = ~clk;

  pll_lock_monitor #(
    .SYNC_STAGES(2), .LOCK_FILTER(8), .RESET_HOLD(4), .LOSS_CNT_W(2)
  ) dut (
    .clock_in       (clk),
    .reset          (reset),
    .locked_async   (locked_async),
    .clear_status   (clear_status),
    .rst_out        (rst_out),
    .ready          (ready),
    .lock_lost      (lock_lost),
`ifdef PLL_LOCK_MONITOR_UPTIME_EN
    .uptime         (uptime),
`endif
    .lock_loss_count(lock_loss_count)
  );

  // One row = hold these inputs for n edges; check outputs after every edge
  typedef struct {
    logic       rs;
    logic       lk;
    logic       clr;
    int         n;
    logic       e_rst;
    logic       e_rdy;
    logic       e_lost;
    logic [1:0] e_cnt;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic add(input logic rs, input logic lk, input logic clr, input int n,
                     input logic er, input logic ey, input logic el, input logic [1:0] ec);
    vec_t v;
    v.rs = rs; v.lk = lk; v.clr = clr; v.n = n;
    v.e_rst = er; v.e_rdy = ey; v.e_lost = el; v.e_cnt = ec;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] sat3(input int k);
    return (k > 3) ? 2'd3 : 2'(k);
  endfunction

  initial begin
    int edges;
    reset = 1'b1; locked_async = 1'b0; clear_status = 1'b0;

    // Fresh lock: reset state, then ready on the 15th edge
    add(1,0,0,3,  1,0,0,0);
    add(0,1,0,14, 1,0,0,0);
    add(0,1,0,1,  0,1,0,0);
    add(0,1,0,5,  0,1,0,0);
    // Loss in RUN: reset re-asserts on the 3rd low edge, then relock
    add(0,0,0,2,  0,1,0,0);
    add(0,0,0,1,  1,0,1,1);
    add(0,0,0,3,  1,0,1,1);
    add(0,1,0,14, 1,0,1,1);
    add(0,1,0,1,  0,1,1,1);
    // One-cycle glitch during FILTER is rejected and not counted
    add(1,0,0,2,  1,0,0,0);
    add(0,1,0,5,  1,0,0,0);
    add(0,0,0,1,  1,0,0,0);
    add(0,1,0,14, 1,0,0,0);
    add(0,1,0,1,  0,1,0,0);
    // Five losses: count 1,2,3,3,3
    for (int k = 1; k <= 5; k++) begin
      add(0,0,0,2,  0,1,(k > 1),sat3(k-1));
      add(0,0,0,1,  1,0,1,sat3(k));
      add(0,1,0,14, 1,0,1,sat3(k));
      add(0,1,0,1,  0,1,1,sat3(k));
    end
    // Loss with clear_status on the loss edge: the loss wins, so count is 1
    add(0,0,0,2,  0,1,1,3);
    add(0,0,1,1,  1,0,1,1);
    // Relock into HOLD, then reset there
    add(0,1,0,12, 1,0,1,1);
    add(1,1,0,1,  1,0,0,0);
    add(0,1,0,14, 1,0,0,0);
    add(0,1,0,1,  0,1,0,0);
    // A loss followed by a lone clear_status pulse while in WAIT
    add(0,0,0,2,  0,1,0,0);
    add(0,0,0,1,  1,0,1,1);
    add(0,0,1,1,  1,0,0,0);
    add(0,0,0,2,  1,0,0,0);

    foreach (tbl[r]) begin
      reset = tbl[r].rs; locked_async = tbl[r].lk; clear_status = tbl[r].clr;
      for (int c = 0; c < tbl[r].n; c++) begin
        @(posedge clk); #1;
        chk($sformatf("row%0d.%0d rst_out", r, c), 32'(rst_out), 32'(tbl[r].e_rst));
        chk($sformatf("row%0d.%0d ready", r, c), 32'(ready), 32'(tbl[r].e_rdy));
        chk($sformatf("row%0d.%0d lock_lost", r, c), 32'(lock_lost), 32'(tbl[r].e_lost));
        chk($sformatf("row%0d.%0d count", r, c), 32'(lock_loss_count), 32'(tbl[r].e_cnt));
      end
    end

    // Bounded measurement of the assertion latency
    reset = 1'b1; locked_async = 1'b0; clear_status = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; locked_async = 1'b1;
    edges = 0;
    while (!ready && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("ready latency", 32'(edges), 32'd15);

`ifdef PLL_LOCK_MONITOR_UPTIME_EN
    chk("uptime entry", uptime, 32'd0);
    repeat (99) @(posedge clk);
    #1 chk("uptime 100th RUN cycle", uptime, 32'd99);
    locked_async = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("uptime after exit", uptime, 32'd0);
    chk("ready after exit", 32'(ready), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
